// File: rtl/program_memory_arbiter_pkg.sv
// Shared definitions for the program memory arbiter: FSM state encoding,
// the NOP instruction returned for rejected fetches and the address-width helper.
package program_memory_arbiter_pkg;

    typedef enum logic [0:0] {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } pm_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Number of word-index bits needed to address 'depth' words (at least 1).
    function automatic int unsigned pm_addr_width(input int unsigned depth);
        int unsigned width;
        width = 32'd1;
        while ((32'd1 << width) < depth) begin
            width = width + 32'd1;
        end
        return width;
    endfunction

endpackage

// File: rtl/program_memory_arbiter_starvation_counter.sv
// pm_starvation_counter: counts consecutive fetch grants taken while the loader
// is waiting, and flags when the loader must be given the port.
module pm_starvation_counter
    import program_memory_arbiter_pkg::*;
#(
    parameter int MAX_FETCH_BURST = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic load_req_i,
    input  logic fetch_gnt_i,
    input  logic load_gnt_i,
    output logic limit_o
);

    localparam int CNT_W = $clog2(MAX_FETCH_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_FETCH_BURST);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: clear when the loader is idle or served, else count fetches that bypassed it.
    always_comb begin
        count_d = count_q;
        if (!load_req_i || load_gnt_i) begin
            count_d = {CNT_W{1'b0}};
        end else if (fetch_gnt_i && (count_q != CNT_MAX)) begin
            count_d = count_q + CNT_W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= {CNT_W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign limit_o = (count_q == CNT_MAX);

endmodule

// File: rtl/program_memory_arbiter.sv
// program_memory_arbiter: shares the single port of a synchronous-read program
// RAM between instruction fetch and a boot/debug loader.
// Optional feature macro: ADDR_CHECK_EN (out-of-range fetches return a NOP with
// fetch_err_o, out-of-range loads are dropped). Without it, addresses wrap.
module program_memory_arbiter
    import program_memory_arbiter_pkg::*;
#(
    parameter int MEMORY_DEPTH    = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_FETCH_BURST = 4,
    localparam int ADDR_W         = pm_addr_width(MEMORY_DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  boot_mode_i,
    input  logic                  fetch_req_i,
    input  logic [DATA_WIDTH-1:0] fetch_addr_i,
    output logic                  fetch_gnt_o,
    output logic                  fetch_valid_o,
    output logic [DATA_WIDTH-1:0] fetch_data_o,
    output logic                  fetch_err_o,
    input  logic                  load_req_i,
    input  logic [DATA_WIDTH-1:0] load_addr_i,
    input  logic [DATA_WIDTH-1:0] load_data_i,
    output logic                  load_gnt_o,
    output logic                  core_stall_o,
    output logic [ADDR_W-1:0]     mem_addr_o,
    output logic                  mem_we_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    pm_state_e             state_q;
    pm_state_e             state_d;
    logic                  rd_pend_q;
    logic                  rd_err_q;
    logic [DATA_WIDTH-1:0] data_hold_q;

    logic                  fetch_gnt_s;
    logic                  load_gnt_s;
    logic                  limit_s;
    logic                  fetch_oor_s;
    logic                  load_oor_s;
    logic [DATA_WIDTH-1:0] data_out_s;
    logic [ADDR_W-1:0]     fetch_idx_s;
    logic [ADDR_W-1:0]     load_idx_s;
    logic                  unused_addr_bits_s;

    assign fetch_idx_s = fetch_addr_i[ADDR_W+1:2];
    assign load_idx_s  = load_addr_i[ADDR_W+1:2];

`ifdef ADDR_CHECK_EN
    assign fetch_oor_s = |fetch_addr_i[DATA_WIDTH-1:ADDR_W+2];
    assign load_oor_s  = |load_addr_i[DATA_WIDTH-1:ADDR_W+2];
`else
    assign fetch_oor_s = 1'b0;
    assign load_oor_s  = 1'b0;
`endif

    // Byte-offset bits (and, without range checking, the high bits) never affect the port.
    assign unused_addr_bits_s = ^{fetch_addr_i[1:0], load_addr_i[1:0],
                                  fetch_addr_i[DATA_WIDTH-1:ADDR_W+2],
                                  load_addr_i[DATA_WIDTH-1:ADDR_W+2]};

    pm_starvation_counter #(
        .MAX_FETCH_BURST(MAX_FETCH_BURST)
    ) u_starve (
        .clk        (clk),
        .reset      (reset),
        .load_req_i (load_req_i),
        .fetch_gnt_i(fetch_gnt_s),
        .load_gnt_i (load_gnt_s),
        .limit_o    (limit_s)
    );

    // Next state and single-winner grant decision.
    always_comb begin
        state_d     = boot_mode_i ? ST_BOOT : ST_RUN;
        fetch_gnt_s = 1'b0;
        load_gnt_s  = 1'b0;
        case (state_q)
            ST_BOOT: begin
                load_gnt_s = load_req_i;
            end
            ST_RUN: begin
                if (fetch_req_i && load_req_i) begin
                    if (limit_s) begin
                        load_gnt_s = 1'b1;
                    end else begin
                        fetch_gnt_s = 1'b1;
                    end
                end else if (fetch_req_i) begin
                    fetch_gnt_s = 1'b1;
                end else if (load_req_i) begin
                    load_gnt_s = 1'b1;
                end else begin
                    fetch_gnt_s = 1'b0;
                    load_gnt_s  = 1'b0;
                end
            end
            default: begin
                state_d     = ST_BOOT;
                fetch_gnt_s = 1'b0;
                load_gnt_s  = 1'b0;
            end
        endcase
    end

    // Returned word: RAM data (or NOP if rejected) in the cycle after a grant, else the held word.
    always_comb begin
        if (rd_pend_q) begin
            if (rd_err_q) begin
                data_out_s = DATA_WIDTH'(NOP_INSTR);
            end else begin
                data_out_s = mem_rdata_i;
            end
        end else begin
            data_out_s = data_hold_q;
        end
    end

    // State, read-pending tracking and held fetch data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_BOOT;
            rd_pend_q   <= 1'b0;
            rd_err_q    <= 1'b0;
            data_hold_q <= {DATA_WIDTH{1'b0}};
        end else begin
            state_q     <= state_d;
            rd_pend_q   <= fetch_gnt_s;
            rd_err_q    <= fetch_gnt_s & fetch_oor_s;
            data_hold_q <= data_out_s;
        end
    end

    assign fetch_gnt_o   = fetch_gnt_s;
    assign load_gnt_o    = load_gnt_s;
    assign core_stall_o  = (state_q == ST_BOOT);
    assign fetch_valid_o = rd_pend_q;
    assign fetch_data_o  = data_out_s;
    assign fetch_err_o   = rd_pend_q & rd_err_q;
    assign mem_addr_o    = load_gnt_s ? load_idx_s : fetch_idx_s;
    assign mem_we_o      = load_gnt_s & ~load_oor_s;
    assign mem_wdata_o   = load_data_i;

endmodule

// File: tb/tb_program_memory_arbiter.sv
// Scoreboard bench for program_memory_arbiter with a behavioural synchronous RAM.
module tb_program_memory_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          boot_mode;
    logic          fetch_req;
    logic [DW-1:0] fetch_addr;
    logic          fetch_gnt;
    logic          fetch_valid;
    logic [DW-1:0] fetch_data;
    logic          fetch_err;
    logic          load_req;
    logic [DW-1:0] load_addr;
    logic [DW-1:0] load_data;
    logic          load_gnt;
    logic          core_stall;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic [DW-1:0] ram [0:31];

    typedef struct {
        logic [DW-1:0] data;
        logic          err;
    } exp_t;

    exp_t exp_q[$];
    int   vec_cnt = 0;
    int   err_cnt = 0;

    always #5 clk = ~clk;

    program_memory_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .boot_mode_i  (boot_mode),
        .fetch_req_i  (fetch_req),
        .fetch_addr_i (fetch_addr),
        .fetch_gnt_o  (fetch_gnt),
        .fetch_valid_o(fetch_valid),
        .fetch_data_o (fetch_data),
        .fetch_err_o  (fetch_err),
        .load_req_i   (load_req),
        .load_addr_i  (load_addr),
        .load_data_i  (load_data),
        .load_gnt_o   (load_gnt),
        .core_stall_o (core_stall),
        .mem_addr_o   (mem_addr),
        .mem_we_o     (mem_we),
        .mem_wdata_o  (mem_wdata),
        .mem_rdata_i  (mem_rdata)
    );

    // Synchronous single-port RAM.
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every returned fetch is compared against the oldest expectation.
    always @(negedge clk) begin
        if (fetch_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("fetch_data", fetch_data, e.data);
                check("fetch_err", {31'd0, fetch_err}, {31'd0, e.err});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_fetch(input logic [DW-1:0] a, input logic [DW-1:0] d, input logic e);
        bit got = 1'b0;
        fetch_req  = 1'b1;
        fetch_addr = a;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (fetch_gnt === 1'b1) begin
                got = 1'b1;
                exp_q.push_back('{data: d, err: e});
            end
            step();
        end
        fetch_req = 1'b0;
        if (!got) check("fetch_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_load(input logic [DW-1:0] a, input logic [DW-1:0] d, input logic exp_we);
        bit got = 1'b0;
        load_req  = 1'b1;
        load_addr = a;
        load_data = d;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (load_gnt === 1'b1) begin
                got = 1'b1;
                check("load_we", {31'd0, mem_we}, {31'd0, exp_we});
            end
            step();
        end
        load_req = 1'b0;
        if (!got) check("load_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 32; i++) ram[i] = 32'd0;
        reset = 1'b1; boot_mode = 1'b1;
        fetch_req = 1'b0; fetch_addr = 32'd0;
        load_req = 1'b0; load_addr = 32'd0; load_data = 32'd0;

        // Reset values
        @(negedge clk); @(negedge clk);
        check("rst_stall", {31'd0, core_stall}, 32'd1);
        check("rst_valid", {31'd0, fetch_valid}, 32'd0);
        check("rst_data", fetch_data, 32'd0);
        check("rst_err", {31'd0, fetch_err}, 32'd0);
        step();
        reset = 1'b0;

        // BOOT: two loads granted back to back, fetch held off
        fetch_req = 1'b1; fetch_addr = 32'h0;
        load_req = 1'b1; load_addr = 32'h0; load_data = 32'h0000_0013;
        @(negedge clk);
        check("boot_lgnt0", {31'd0, load_gnt}, 32'd1);
        check("boot_fgnt0", {31'd0, fetch_gnt}, 32'd0);
        check("boot_addr0", {27'd0, mem_addr}, 32'd0);
        check("boot_we0", {31'd0, mem_we}, 32'd1);
        step();
        load_addr = 32'h4; load_data = 32'h0050_0093;
        @(negedge clk);
        check("boot_lgnt1", {31'd0, load_gnt}, 32'd1);
        check("boot_fgnt1", {31'd0, fetch_gnt}, 32'd0);
        check("boot_addr1", {27'd0, mem_addr}, 32'd1);
        step();
        load_req = 1'b0; fetch_req = 1'b0;

        // BOOT -> RUN, fetch 0x4
        boot_mode = 1'b0; fetch_req = 1'b1; fetch_addr = 32'h4;
        @(negedge clk);
        check("exit_stall", {31'd0, core_stall}, 32'd1);
        check("exit_fgnt", {31'd0, fetch_gnt}, 32'd0);
        step();
        @(negedge clk);
        check("run_stall", {31'd0, core_stall}, 32'd0);
        check("run_fgnt", {31'd0, fetch_gnt}, 32'd1);
        check("run_addr", {27'd0, mem_addr}, 32'd1);
        if (fetch_gnt === 1'b1) exp_q.push_back('{data: 32'h0050_0093, err: 1'b0});
        step();
        fetch_req = 1'b0;
        @(negedge clk);
        step();
        @(negedge clk);
        check("hold_valid", {31'd0, fetch_valid}, 32'd0);
        check("hold_data", fetch_data, 32'h0050_0093);
        step();

        // Starvation bound: F F F F L repeating
        fetch_req = 1'b1; fetch_addr = 32'h0;
        load_req = 1'b1; load_addr = 32'h8; load_data = 32'hA5A5_0001;
        for (int i = 0; i < 10; i++) begin
            logic exp_f;
            exp_f = ((i % 5) != 4);
            @(negedge clk);
            check("burst_fgnt", {31'd0, fetch_gnt}, {31'd0, exp_f});
            check("burst_lgnt", {31'd0, load_gnt}, {31'd0, ~exp_f});
            if (exp_f) exp_q.push_back('{data: 32'h0000_0013, err: 1'b0});
            step();
        end
        fetch_req = 1'b0; load_req = 1'b0;
        do_fetch(32'h8, 32'hA5A5_0001, 1'b0);

        // Write then read of the same word on the next cycle
        do_load(32'hC, 32'hDEAD_BEEF, 1'b1);
        do_fetch(32'hC, 32'hDEAD_BEEF, 1'b0);

        // Out-of-range / wrapping addresses
`ifdef ADDR_CHECK_EN
        do_fetch(32'h84, 32'h0000_0013, 1'b1);
        do_fetch(32'h100, 32'h0000_0013, 1'b1);
        do_load(32'h90, 32'h1111_2222, 1'b0);
        do_fetch(32'h10, 32'h0000_0000, 1'b0);
`else
        do_fetch(32'h84, 32'h0050_0093, 1'b0);
        do_fetch(32'h100, 32'h0000_0013, 1'b0);
        do_load(32'h90, 32'h1111_2222, 1'b1);
        do_fetch(32'h10, 32'h1111_2222, 1'b0);
`endif

        // Fetch granted in the cycle boot_mode rises
        fetch_req = 1'b1; fetch_addr = 32'h4; boot_mode = 1'b1;
        @(negedge clk);
        check("rise_fgnt", {31'd0, fetch_gnt}, 32'd1);
        exp_q.push_back('{data: 32'h0050_0093, err: 1'b0});
        step();
        @(negedge clk);
        check("rise_stall", {31'd0, core_stall}, 32'd1);
        check("rise_fgnt_blk", {31'd0, fetch_gnt}, 32'd0);
        step();
        @(negedge clk);
        check("rise_fgnt_blk2", {31'd0, fetch_gnt}, 32'd0);
        step();
        fetch_req = 1'b0;

        // Reset during a pending read
        boot_mode = 1'b0;
        step();
        fetch_req = 1'b1; fetch_addr = 32'h0;
        @(negedge clk);
        check("rstmid_fgnt", {31'd0, fetch_gnt}, 32'd1);
        reset = 1'b1;
        fetch_req = 1'b0;
        @(negedge clk);
        check("rstmid_valid", {31'd0, fetch_valid}, 32'd0);
        check("rstmid_stall", {31'd0, core_stall}, 32'd1);
        step();
        reset = 1'b0;
        step();
        step();

        check("queue_empty", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
